// File: rtl/tick_gen.sv
// Programmable enable-strobe generator: one-cycle pulse every div_cur+1 cycles, periodic or one-shot.
// Define TICK_GEN_CNT_EN to add the wrapping tick_cnt output.
module tick_gen #(
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned DEFAULT_DIV = 49999999,
    parameter int unsigned TCNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              oneshot,
    input  logic              div_load,
    input  logic [CNT_W-1:0]  div_val,
    output logic              enable,
    output logic              active,
`ifdef TICK_GEN_CNT_EN
    output logic [TCNT_W-1:0] tick_cnt,
`endif
    output logic [CNT_W-1:0]  div_cur
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             mode_os_q, mode_os_d;
    logic             enable_q, enable_d;
    logic             active_q, active_d;
    logic             take_pend;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        mode_os_d  = mode_os_q;
        enable_d   = 1'b0;
        active_d   = active_q;
        take_pend  = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d     = '0;
                active_d  = 1'b0;
                take_pend = pend_q;
                if (run) begin
                    state_d   = StRun;
                    mode_os_d = oneshot;
                    active_d  = 1'b1;
                end
            end
            StRun: begin
                // Stop has priority over a coincident terminal count.
                if (!run) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    active_d = 1'b0;
                end else if (cnt_q == div_cur_q) begin
                    cnt_d     = '0;
                    enable_d  = 1'b1;
                    take_pend = pend_q;
                    if (mode_os_q) begin
                        state_d  = StDone;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                active_d  = 1'b0;
                take_pend = pend_q;
                if (!run) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                cnt_d    = '0;
                active_d = 1'b0;
            end
        endcase

        // A load in the same cycle as the reload becomes the next pending value.
        if (take_pend) begin
            div_cur_d = div_pend_q;
            pend_d    = 1'b0;
        end
        if (div_load) begin
            div_pend_d = div_val;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_cur_q  <= CNT_W'(DEFAULT_DIV);
            div_pend_q <= '0;
            pend_q     <= 1'b0;
            mode_os_q  <= 1'b0;
            enable_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            mode_os_q  <= mode_os_d;
            enable_q   <= enable_d;
            active_q   <= active_d;
        end
    end

`ifdef TICK_GEN_CNT_EN
    logic [TCNT_W-1:0] tick_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (enable_d) begin
            tick_cnt_q <= tick_cnt_q + TCNT_W'(1);
        end
    end

    assign tick_cnt = tick_cnt_q;
`endif

    assign enable  = enable_q;
    assign active  = active_q;
    assign div_cur = div_cur_q;

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a period-timestamp model.
module tb_tick_gen;

    localparam int CW  = 8;
    localparam int DEF = 4;
    localparam int TW  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          oneshot = 1'b0;
    logic          div_load = 1'b0;
    logic [CW-1:0] div_val = '0;
    logic          enable;
    logic          active;
    logic [CW-1:0] div_cur;
`ifdef TICK_GEN_CNT_EN
    logic [TW-1:0] tick_cnt;
`endif

    int errors = 0;
    int checks = 0;

    tick_gen #(
        .CNT_W      (CW),
        .DEFAULT_DIV(DEF),
        .TCNT_W     (TW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .oneshot (oneshot),
        .div_load(div_load),
        .div_val (div_val),
        .enable  (enable),
        .active  (active),
`ifdef TICK_GEN_CNT_EN
        .tick_cnt(tick_cnt),
`endif
        .div_cur (div_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a tick is due when div+1 edges have passed since the period began.
    longint t = 0;
    longint m_start = 0;
    int     m_state = 0;  // 0 idle, 1 run, 2 done
    int     m_div = DEF;
    int     m_pval = 0;
    int     m_tcnt = 0;
    bit     m_pend = 0, m_os = 0, m_en = 0, m_act = 0, m_valid = 0;

    always @(posedge clk) begin
        t++;
        if (reset) begin
            m_valid = 1;
            m_state = 0;
            m_div   = DEF;
            m_pend  = 0;
            m_en    = 0;
            m_act   = 0;
            m_tcnt  = 0;
        end else if (m_valid) begin
            m_en = 0;
            case (m_state)
                0: begin
                    if (m_pend) begin m_div = m_pval; m_pend = 0; end
                    if (run) begin
                        m_state = 1;
                        m_os    = oneshot;
                        m_start = t;
                        m_act   = 1;
                    end
                end
                1: begin
                    if (!run) begin
                        m_state = 0;
                        m_act   = 0;
                    end else if (t - m_start == longint'(m_div) + 1) begin
                        m_en    = 1;
                        m_start = t;
                        if (m_pend) begin m_div = m_pval; m_pend = 0; end
                        if (m_os) begin m_state = 2; m_act = 0; end
                    end
                end
                default: begin
                    if (m_pend) begin m_div = m_pval; m_pend = 0; end
                    if (!run) m_state = 0;
                end
            endcase
            if (m_en) m_tcnt = (m_tcnt + 1) % 65536;
            if (div_load) begin m_pval = int'(div_val); m_pend = 1; end
        end
        #2;
        if (m_valid) begin
            chk("model_enable", 32'(enable), 32'(m_en));
            chk("model_active", 32'(active), 32'(m_act));
            chk("model_div_cur", 32'(div_cur), 32'(m_div));
`ifdef TICK_GEN_CNT_EN
            chk("model_tick_cnt", 32'(tick_cnt), 32'(m_tcnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        repeat (2) tick();
        reset = 1'b0;
        chk("rst_enable", 32'(enable), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_div_cur", 32'(div_cur), 4);
`ifdef TICK_GEN_CNT_EN
        chk("rst_tick_cnt", 32'(tick_cnt), 0);
`endif

        // Periodic, then a reload two cycles into the second period.
        run = 1'b1;
        oneshot = 1'b0;
        tick();
        chk("per_active_rise", 32'(active), 1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("per_enable", 32'(enable), 32'(k == 5 || k == 10 || k == 13 || k == 16));
            if (k == 9) chk("reload_old_div", 32'(div_cur), 4);
            if (k == 10) chk("reload_new_div", 32'(div_cur), 2);
            div_load = (k == 6);
            div_val  = 8'd2;
        end
        run = 1'b0;
        tick();
        chk("stop_active", 32'(active), 0);
        div_load = 1'b1;
        div_val  = 8'd4;
        tick();
        div_load = 1'b0;
        tick();
        chk("idle_reload", 32'(div_cur), 4);

        // One-shot, twice.
        oneshot = 1'b1;
        run = 1'b1;
        tick();
        chk("os_active_rise", 32'(active), 1);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (enable) n++;
            if (k == 5) begin
                chk("os_enable_at5", 32'(enable), 1);
                chk("os_active_fall", 32'(active), 0);
            end
        end
        chk("os_pulse_count", 32'(n), 1);
        run = 1'b0;
        repeat (2) tick();
        run = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (enable) n++;
        end
        chk("os_rearm_count", 32'(n), 1);
        run = 1'b0;
        tick();

        // Stop on the terminal-count cycle suppresses the pulse.
        oneshot = 1'b0;
        run = 1'b1;
        repeat (5) tick();
        run = 1'b0;
        tick();
        chk("stop_tc_enable", 32'(enable), 0);
        chk("stop_tc_active", 32'(active), 0);
        tick();
        chk("stop_tc_enable2", 32'(enable), 0);
        run = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("restart_enable", 32'(enable), 32'(k == 5));
        end

        // Divisor of zero: strobe on every RUN cycle.
        run = 1'b0;
        tick();
        div_load = 1'b1;
        div_val  = 8'd0;
        tick();
        div_load = 1'b0;
        run = 1'b1;
        tick();
        chk("div0_div_cur", 32'(div_cur), 0);
        chk("div0_active", 32'(active), 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("div0_enable", 32'(enable), 1);
        end

        // Reset mid-period with a pending load.
        run = 1'b0;
        tick();
        div_load = 1'b1;
        div_val  = 8'd7;
        tick();
        div_load = 1'b0;
        tick();
        run = 1'b1;
        repeat (3) tick();
        div_load = 1'b1;
        div_val  = 8'd9;
        tick();
        div_load = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_enable", 32'(enable), 0);
        chk("mid_rst_active", 32'(active), 0);
        chk("mid_rst_div_cur", 32'(div_cur), 4);
`ifdef TICK_GEN_CNT_EN
        chk("mid_rst_tick_cnt", 32'(tick_cnt), 0);
`endif
        tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) chk("post_rst_enable", 32'(enable), 1);
        end
        chk("post_rst_div_cur", 32'(div_cur), 4);

`ifdef TICK_GEN_CNT_EN
        run = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        div_load = 1'b1;
        div_val  = 8'd0;
        tick();
        div_load = 1'b0;
        tick();
        run = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 70000 && n < 65536; i++) begin
            tick();
            if (enable) n++;
        end
        chk("wrap_pulses", 32'(n), 65536);
        chk("wrap_tick_cnt", 32'(tick_cnt), 0);
        run = 1'b0;
        tick();
`endif

        // Randomized traffic, checked only by the model.
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0) run = ~run;
            oneshot  = 1'($urandom_range(0, 1));
            div_load = ($urandom_range(0, 14) == 0);
            div_val  = 8'($urandom_range(0, 9));
            tick();
        end
        reset = 1'b0;
        div_load = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
Parametrised, runtime-programmable enable-pulse generator and the successor to the fixed 1 Hz enable generator. Produces single-cycle enable strobes every DIV+1 clock cycles. Supports start/stop control, a periodic or one-shot mode, and a glitch-free divisor reload. Sits beside the system clock and feeds clock-enable inputs of slow logic: LED blinkers, debouncers, UART baud ticks.

Parameters:
CNT_W, 26, width of the divide counter and divisor registers
DEFAULT_DIV, 49999999, divisor loaded at reset; 1 Hz from 50 MHz
TCNT_W, 16, width of tick_cnt; used only with TICK_GEN_CNT_EN

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = generate ticks, 0 = stop and return to IDLE
oneshot  in  1  mode select, sampled on IDLE->RUN; 1 = single tick, 0 = periodic
div_load  in  1  one-cycle strobe; captures div_val as the pending divisor
div_val  in  CNT_W  new divisor; tick period = div_val+1 cycles
enable  out  1  registered tick strobe, high for exactly one cycle
active  out  1  registered; high while the FSM is in RUN
div_cur  out  CNT_W  divisor currently in use

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values: enable=0, active=0, counter=0, div_cur=DEFAULT_DIV, pending flag cleared, FSM=IDLE. Reset overrides every other input.
- FSM states: IDLE, RUN, DONE.
  - IDLE: counter held at 0, enable=0. When run=1: go to RUN, latch oneshot into mode_os, set active=1 on the same edge.
  - RUN: counter increments by 1 each cycle.
  - RUN, counter==div_cur: counter<=0, enable<=1 on that edge. If mode_os=1, go to DONE and set active<=0 on the same edge.
  - RUN, run=0: go to IDLE, counter<=0, active<=0, no enable. Stop wins over a simultaneous terminal count.
  - DONE: enable=0, active=0. Stays in DONE until run=0, then goes to IDLE. A new one-shot needs run to go low, then high.
- Timing: active rises at edge E0. First enable is high during the cycle after edge E0+div_cur+1. The period is then div_cur+1 cycles. enable is never high for two consecutive cycles unless div_cur=0.
- div_cur=0: enable is high on every cycle while in RUN. In one-shot mode it produces a single pulse one cycle after active rises.
- Divisor reload:
  - div_load=1 stores div_val in div_pend and sets the pending flag.
  - In IDLE or DONE, div_cur<=div_pend on the next edge.
  - In RUN, div_cur updates only on the terminal-count edge, so the current period always completes with the old value.
  - div_load coinciding with terminal count: the new value applies from the next period.
  - A second div_load before the update overwrites div_pend; last write wins.
- Counter arithmetic is unsigned CNT_W bits. The counter never exceeds div_cur because compare-and-clear precedes increment. No wrap-around path exists.
- div_cur is a plain register output: no combinational path from div_val.
- Reset mid-period or with a load pending: the pending value is discarded and div_cur returns to DEFAULT_DIV.

Optional Feature:
Macro TICK_GEN_CNT_EN.
- Defined: adds output tick_cnt (out, TCNT_W). It resets to 0 and increments by 1 on every edge where enable<=1. It wraps from all-ones to 0 and is not cleared by run or mode changes.
- Undefined: the tick_cnt port and its register are absent. All other behaviour is identical.

Test Plan:
- Test parameters: CNT_W=8, DEFAULT_DIV=4. Reset, then run=1 held, oneshot=0 -> active=1 after the first edge. enable pulses one cycle wide every 5 cycles; first pulse 5 cycles after active rises.
- Periodic run, div_load with div_val=2 two cycles into a period -> that period still lasts 5 cycles. div_cur changes to 2 on the terminal edge. Subsequent pulses every 3 cycles.
- oneshot=1, run=1 held for 20 cycles -> exactly one enable, 5 cycles after active rises. active falls on the same edge. After run=0 then run=1, exactly one more pulse.
- run dropped on the cycle counter==4 -> no enable pulse. active=0 next cycle. Counter reads 0 on restart.
- div_val=0 loaded in IDLE, then run=1 -> div_cur=0 next edge. enable stays high on every cycle of RUN.
- Pending div_val=9 loaded in RUN, then reset asserted mid-period -> enable=0, active=0, div_cur=4. With TICK_GEN_CNT_EN, tick_cnt=0, and 65536 pulses wrap tick_cnt back to 0.
